fifo_buffer: RTL and testbench

FIFO_BUFFER -- requirements
Module: fifo_buffer

---
 rtl/fifo_buffer_if.sv | 30 +++
 rtl/fifo_buffer.sv | 71 +++++++
 tb/tb_fifo_buffer.sv | 137 +++++++++++++
 3 files changed

// File: rtl/fifo_buffer_if.sv
// Handshake bundle for fifo_buffer: the producer/consumer side drives requests
// and data, and the FIFO returns registered read data and status flags.
interface fifo_buffer_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] Data_in;
    logic                  write;
    logic                  read;
    logic [DATA_WIDTH-1:0] Data_out;
    logic                  empty;
    logic                  full;

    modport master (
        output Data_in,
        output write,
        output read,
        input  Data_out,
        input  empty,
        input  full
    );

    modport slave (
        input  Data_in,
        input  write,
        input  read,
        output Data_out,
        output empty,
        output full
    );
endinterface

// File: rtl/fifo_buffer.sv
// Synchronous single-clock FIFO with registered read data and count-decoded
// empty/full flags; a read and a write may complete in the same cycle even when full.
module fifo_buffer #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 8
) (
    input logic         clk,
    input logic         rst,
    fifo_buffer_if.slave bus
);
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    localparam logic [CntW-1:0] CountMax = CntW'(DEPTH);
    localparam logic [CntW-1:0] CountOne = CntW'(1);
    localparam logic [PtrW-1:0] PtrOne   = PtrW'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [PtrW-1:0]       wr_ptr_q;
    logic [PtrW-1:0]       rd_ptr_q;
    logic [CntW-1:0]       count_q;
    logic [DATA_WIDTH-1:0] data_out_q;

    logic rd_accept;
    logic wr_accept;
    logic empty_flag;
    logic full_flag;

    always_comb begin
        empty_flag = (count_q == '0);
        full_flag  = (count_q == CountMax);
        rd_accept  = bus.read && !empty_flag;
        // A full FIFO still takes a write when a read frees a slot on the same edge.
        wr_accept  = bus.write && (!full_flag || rd_accept);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            data_out_q <= '0;
        end else begin
            if (wr_accept) begin
                wr_ptr_q <= wr_ptr_q + PtrOne;
            end
            if (rd_accept) begin
                rd_ptr_q   <= rd_ptr_q + PtrOne;
                data_out_q <= mem[rd_ptr_q];
            end
            unique case ({wr_accept, rd_accept})
                2'b10:   count_q <= count_q + CountOne;
                2'b01:   count_q <= count_q - CountOne;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage is not reset; only the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (wr_accept && !rst) begin
            mem[wr_ptr_q] <= bus.Data_in;
        end
    end

    assign bus.Data_out = data_out_q;
    assign bus.empty    = empty_flag;
    assign bus.full     = full_flag;

endmodule

// File: tb/tb_fifo_buffer.sv
// Directed plus random test of fifo_buffer against a queue-based FIFO model.
module tb_fifo_buffer;
    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 8;

    logic clk;
    logic rst;

    fifo_buffer_if #(.DATA_WIDTH(DW)) bus ();

    fifo_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests;
    int fails;

    logic [DW-1:0] model_q [$];
    logic [DW-1:0] model_dout;

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_data(input string tag, input logic [DW-1:0] obs,
                              input logic [DW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check_data({tag, "_dout"}, bus.Data_out, model_dout);
        check_bit({tag, "_empty"}, bus.empty, (model_q.size() == 0));
        check_bit({tag, "_full"}, bus.full, (model_q.size() == DEPTH));
    endtask

    // Drive one cycle of requests (called just after a falling edge), apply the
    // FIFO rules to the model at the rising edge, then check 1 ns later.
    task automatic step(input logic w, input logic r, input logic [DW-1:0] d, input string tag);
        bus.write   = w;
        bus.read    = r;
        bus.Data_in = d;
        @(posedge clk);
        if (!rst) begin
            if (r && model_q.size() > 0) model_dout = model_q.pop_front();
            if (w && model_q.size() < DEPTH) model_q.push_back(d);
        end
        #1;
        check_all(tag);
        @(negedge clk);
        bus.write = 1'b0;
        bus.read  = 1'b0;
    endtask

    initial begin
        tests       = 0;
        fails       = 0;
        rst         = 1'b0;
        bus.write   = 1'b0;
        bus.read    = 1'b0;
        bus.Data_in = '0;
        model_dout  = '0;

        // Reset before any rising clock edge has occurred.
        #2 rst = 1'b1;
        #1;
        check_all("reset_async");
        #14 rst = 1'b0;
        @(negedge clk);
        check_all("reset_release");

        // Fill past capacity: 9..11 must be dropped.
        for (int i = 1; i <= 11; i++) step(1'b1, 1'b0, DW'(i), "fill");
        check_bit("fill_full_final", bus.full, 1'b1);

        // Drain with two extra reads while empty.
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, '0, "drain");
        check_data("drain_hold", bus.Data_out, 8'd8);

        // Offset pointers, then wrap around with a full load.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, DW'($urandom_range(0, 255)), "off_wr");
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, '0, "off_rd");
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, DW'(8'hA0 + i), "wrap_wr");
        check_bit("wrap_full", bus.full, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, '0, "wrap_rd");

        // Simultaneous read+write at empty, mid level and full.
        step(1'b1, 1'b1, 8'h51, "rw_empty");
        check_bit("rw_empty_not_empty", bus.empty, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, DW'(8'h60 + i), "to_mid");
        step(1'b1, 1'b1, 8'h70, "rw_mid");
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, DW'(8'h80 + i), "to_full");
        step(1'b1, 1'b1, 8'h90, "rw_full");
        check_bit("rw_full_still_full", bus.full, 1'b1);
        for (int i = 0; i < 9; i++) step(1'b0, 1'b1, '0, "rw_drain");

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 DW'($urandom_range(0, 255)), "rand");
        end
        for (int i = 0; i < 9; i++) step(1'b0, 1'b1, '0, "rand_drain");

        // Reset mid-operation at count 5, between clock edges.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, DW'(8'hC0 + i), "pre_rst");
        step(1'b0, 1'b1, '0, "pre_rst_rd");
        step(1'b1, 1'b0, 8'hC5, "pre_rst_wr");
        #2 rst = 1'b1;
        model_q.delete();
        model_dout = '0;
        #1;
        check_all("rst_mid");
        step(1'b1, 1'b1, 8'hEE, "rst_held");
        rst = 1'b0;
        step(1'b0, 1'b1, '0, "post_rst_rd");
        check_data("post_rst_dout", bus.Data_out, 8'h00);
        step(1'b1, 1'b0, 8'h3C, "post_rst_wr");
        step(1'b0, 1'b1, '0, "post_rst_rd2");
        check_data("post_rst_dout2", bus.Data_out, 8'h3C);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
